// File: rtl/hash160_msg_padder_if.sv
// Block handoff between the message padder and the SHA-256 compression core.
interface hash160_msg_padder_if;
  logic [511:0] o_block;
  logic         o_block_valid;
  logic         i_block_ready;
  logic         o_last;

  modport master (
    output o_block,
    output o_block_valid,
    output o_last,
    input  i_block_ready
  );

  modport slave (
    input  o_block,
    input  o_block_valid,
    input  o_last,
    output i_block_ready
  );
endinterface

// File: rtl/hash160_msg_padder.sv
// Hash160 front end: frames MSG_BYTES bytes after a start byte, applies SHA-256 padding and
// hands one or two 512-bit blocks to the compression core over valid/ready.
module hash160_msg_padder #(
  parameter int unsigned MSG_BYTES  = 64,
  parameter logic [7:0]  START_BYTE = 8'hAA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   i_text,
  output logic                         o_busy,
  hash160_msg_padder_if.master         blk
);

  if (MSG_BYTES < 1 || MSG_BYTES > 64) begin : g_bad_msg_bytes
    $error("hash160_msg_padder: MSG_BYTES must be in 1..64");
  end

  localparam logic [63:0] LenBits   = 64'(MSG_BYTES) * 64'd8;
  localparam bit          TwoBlocks = (MSG_BYTES > 55);
  localparam logic [6:0]  LastIdx   = 7'(MSG_BYTES - 1);

  // Pad bits OR-ed onto the captured message to form block 0.
  function automatic logic [511:0] pad0_f();
    logic [511:0] p;
    int           idx;
    p   = '0;
    idx = (MSG_BYTES < 64) ? 511 - 8 * int'(MSG_BYTES) : 511;
    if (MSG_BYTES < 64) p[idx -: 8] = 8'h80;
    if (!TwoBlocks) p[63:0] = LenBits;
    return p;
  endfunction

  function automatic logic [511:0] pad1_f();
    logic [511:0] p;
    p = '0;
    if (MSG_BYTES == 64) p[511:504] = 8'h80;
    p[63:0] = LenBits;
    return p;
  endfunction

  localparam logic [511:0] Pad0 = pad0_f();
  localparam logic [511:0] Pad1 = pad1_f();

  typedef enum logic [1:0] {StIdle, StCollect, StEmit0, StEmit1} state_e;

  state_e       state_q, state_d;
  logic [6:0]   count_q, count_d;
  logic [511:0] msg_q, msg_d;
  logic [511:0] block_q, block_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;
  logic [511:0] msg_wr;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    msg_d   = msg_q;
    block_d = block_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;

    msg_wr = msg_q;
    msg_wr[511 - 8 * int'(count_q) -: 8] = i_text;

    unique case (state_q)
      StIdle: begin
        if (i_text == START_BYTE) begin
          state_d = StCollect;
          count_d = '0;
          busy_d  = 1'b1;
          msg_d   = '0;
        end
      end
      StCollect: begin
        msg_d   = msg_wr;
        count_d = count_q + 7'd1;
        if (count_q == LastIdx) begin
          state_d = StEmit0;
          block_d = msg_wr | Pad0;
          valid_d = 1'b1;
          last_d  = !TwoBlocks;
        end
      end
      StEmit0: begin
        if (blk.i_block_ready) begin
          if (TwoBlocks) begin
            // Block 1 is presented on the very next cycle, no bubble.
            state_d = StEmit1;
            block_d = Pad1;
            last_d  = 1'b1;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      StEmit1: begin
        if (blk.i_block_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      msg_q   <= '0;
      block_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      msg_q   <= msg_d;
      block_q <= block_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign blk.o_block       = block_q;
  assign blk.o_block_valid = valid_q;
  assign blk.o_last        = last_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_hash160_msg_padder.sv
// Bench for hash160_msg_padder: default (64-byte) and 3-byte instances against a queue-based
// SHA-256 padding model.
module tb_hash160_msg_padder;

  logic       clk;
  logic       rst;
  logic [7:0] a_text, b_text;
  logic       a_busy, b_busy;
  int         n_asserts = 0;
  int         n_fail    = 0;
  int         xfer_a    = 0;
  int         xfer_b    = 0;

  hash160_msg_padder_if bus_a ();
  hash160_msg_padder_if bus_b ();

  hash160_msg_padder u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .i_text (a_text),
    .o_busy (a_busy),
    .blk    (bus_a.master)
  );

  hash160_msg_padder #(.MSG_BYTES(3), .START_BYTE(8'hAA)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .i_text (b_text),
    .o_busy (b_busy),
    .blk    (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus_a.o_block_valid && bus_a.i_block_ready) xfer_a <= xfer_a + 1;
    if (!rst && bus_b.o_block_valid && bus_b.i_block_ready) xfer_b <= xfer_b + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: message, 0x80, zero fill to 56 mod 64, 64-bit big-endian bit length.
  task automatic model(input logic [7:0] msg[$], output logic [511:0] b0,
                       output logic [511:0] b1, output int nb);
    logic [7:0]  p[$];
    logic [63:0] len;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    nb = p.size() / 64;
    b0 = '0;
    b1 = '0;
    for (int i = 0; i < 64; i++) b0[511 - 8*i -: 8] = p[i];
    if (nb == 2) for (int i = 0; i < 64; i++) b1[511 - 8*i -: 8] = p[64 + i];
  endtask

  function automatic logic [511:0] o_blk(input bit sel);
    return sel ? bus_b.o_block : bus_a.o_block;
  endfunction
  function automatic logic o_val(input bit sel);
    return sel ? bus_b.o_block_valid : bus_a.o_block_valid;
  endfunction
  function automatic logic o_lst(input bit sel);
    return sel ? bus_b.o_last : bus_a.o_last;
  endfunction
  function automatic logic o_bsy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction
  function automatic int n_xfer(input bit sel);
    return sel ? xfer_b : xfer_a;
  endfunction

  task automatic drive(input bit sel, input logic [7:0] t, input logic r);
    if (sel) begin
      b_text = t;
      bus_b.i_block_ready = r;
    end else begin
      a_text = t;
      bus_a.i_block_ready = r;
    end
  endtask

  // Full frame: start byte, message, then both emit phases with the given ready stalls.
  // START_BYTE is driven throughout emission to confirm it is ignored there.
  task automatic run_frame(input bit sel, input logic [7:0] msg[$], input int stall0,
                           input int stall1, input string tag);
    logic [511:0] b0, b1;
    int           nb, x0;
    model(msg, b0, b1, nb);
    drive(sel, 8'hAA, 1'($urandom_range(0, 1)));
    step();
    chk({tag, " busy after start"}, 512'(o_bsy(sel)), 512'(1));
    chk({tag, " no valid in collect"}, 512'(o_val(sel)), 512'(0));
    foreach (msg[i]) begin
      drive(sel, msg[i], 1'($urandom_range(0, 1)));
      step();
    end
    x0 = n_xfer(sel);
    drive(sel, 8'hAA, 1'b0);
    chk({tag, " block0"}, o_blk(sel), b0);
    chk({tag, " valid0"}, 512'(o_val(sel)), 512'(1));
    chk({tag, " last0"}, 512'(o_lst(sel)), 512'(nb == 1));
    for (int s = 0; s < stall0; s++) begin
      drive(sel, 8'hAA, 1'b0);
      step();
      chk({tag, " block0 stall"}, o_blk(sel), b0);
      chk({tag, " valid0 stall"}, 512'(o_val(sel)), 512'(1));
      chk({tag, " last0 stall"}, 512'(o_lst(sel)), 512'(nb == 1));
    end
    drive(sel, 8'hAA, 1'b1);
    step();
    if (nb == 2) begin
      chk({tag, " block1"}, o_blk(sel), b1);
      chk({tag, " valid1"}, 512'(o_val(sel)), 512'(1));
      chk({tag, " last1"}, 512'(o_lst(sel)), 512'(1));
      chk({tag, " busy emit1"}, 512'(o_bsy(sel)), 512'(1));
      for (int s = 0; s < stall1; s++) begin
        drive(sel, 8'hAA, 1'b0);
        step();
        chk({tag, " block1 stall"}, o_blk(sel), b1);
        chk({tag, " valid1 stall"}, 512'(o_val(sel)), 512'(1));
      end
      drive(sel, 8'hAA, 1'b1);
      step();
    end
    chk({tag, " idle valid"}, 512'(o_val(sel)), 512'(0));
    chk({tag, " idle busy"}, 512'(o_bsy(sel)), 512'(0));
    chk({tag, " idle last"}, 512'(o_lst(sel)), 512'(0));
    chk({tag, " block held"}, o_blk(sel), (nb == 2) ? b1 : b0);
    chk({tag, " transfers"}, 512'(n_xfer(sel) - x0), 512'(nb));
    drive(sel, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] m[$];
    logic [7:0] noise[4];

    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h00, 1'b1);
    step();
    step();
    chk("reset block", bus_a.o_block, '0);
    chk("reset valid", 512'(bus_a.o_block_valid), 512'(0));
    chk("reset last", 512'(bus_a.o_last), 512'(0));
    chk("reset busy", 512'(a_busy), 512'(0));
    chk("reset busy b", 512'(b_busy), 512'(0));
    rst = 1'b0;
    step();

    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(i));
    run_frame(1'b0, m, 0, 0, "ramp");
    run_frame(1'b0, m, 5, 3, "ramp stall");

    noise = '{8'h55, 8'h00, 8'hAB, 8'hFF};
    foreach (noise[i]) begin
      drive(1'b0, noise[i], 1'b1);
      step();
      chk("noise busy", 512'(a_busy), 512'(0));
      chk("noise valid", 512'(bus_a.o_block_valid), 512'(0));
    end
    run_frame(1'b0, m, 0, 0, "after noise");

    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'hAA);
    run_frame(1'b0, m, 2, 1, "all aa");

    // Reset mid-frame; byte 20 is presented on the reset edge, 21..63 afterwards.
    drive(1'b0, 8'hAA, 1'b1);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'(i), 1'b1);
      step();
    end
    rst = 1'b1;
    drive(1'b0, 8'd20, 1'b1);
    step();
    chk("midreset block", bus_a.o_block, '0);
    chk("midreset valid", 512'(bus_a.o_block_valid), 512'(0));
    chk("midreset last", 512'(bus_a.o_last), 512'(0));
    chk("midreset busy", 512'(a_busy), 512'(0));
    rst = 1'b0;
    for (int i = 21; i < 64; i++) begin
      drive(1'b0, 8'(i), 1'b1);
      step();
    end
    chk("post reset busy", 512'(a_busy), 512'(0));
    chk("post reset valid", 512'(bus_a.o_block_valid), 512'(0));
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(i));
    run_frame(1'b0, m, 1, 0, "after reset");

    for (int f = 0; f < 4; f++) begin
      m = {};
      for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
      run_frame(1'b0, m, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand64");
    end

    m = {8'h61, 8'h62, 8'h63};
    run_frame(1'b1, m, 0, 0, "abc");
    chk("abc literal", bus_b.o_block, {32'h61626380, 416'b0, 64'h18});
    for (int f = 0; f < 4; f++) begin
      m = {};
      for (int i = 0; i < 3; i++) m.push_back(8'($urandom));
      run_frame(1'b1, m, int'($urandom_range(0, 3)), 0, "rand3");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
